icb_usram_bridge: RTL and testbench
===================================

ICB_USRAM_BRIDGE -- requirements
Module: icb_usram_bridge

Interface
REQ-001 SHALL have parameter: USRAM_DEPTH, 4096, number of 64-bit usram words; must be a power of two, at most 8192.
REQ-002 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: icb_cmd_valid in 1, icb_cmd_ready out 1, icb_cmd_read in 1, icb_cmd_addr in 32, icb_cmd_wdata in 32, icb_cmd_wmask in 4  ICB slave command channel.
REQ-005 SHALL have ports: icb_rsp_valid out 1, icb_rsp_ready in 1, icb_rsp_rdata out 32, icb_rsp_err out 1  ICB slave response channel.
REQ-006 SHALL have ports: start out 1 (one-cycle pulse), done in 1 (level or pulse), input_base out 32, output_base out 32  accelerator control.
REQ-007 SHALL have ports: usram_addr out 32 (64-bit word index, zero-extended), usram_wdata out 64, usram_write_en out 1, usram_rdata in 64 (valid one cycle after usram_addr)  unified SRAM port.

Function
REQ-008 SHALL decode icb_cmd_addr[16]: 0 = CSR window, 1 = usram window; word index = icb_cmd_addr[15:3], half select = icb_cmd_addr[2].
REQ-009 SHALL map CSR offsets (addr[7:0]): 0x00 START (W: bit0=1 fires start; R: 0), 0x04 DONE (bit0 sticky, W1C), 0x08 INPUT_BASE RW, 0x0C OUTPUT_BASE RW, 0x10 BUSY RO bit0.
REQ-010 SHALL run FSM IDLE, RD, CAP, WR, RSP; single outstanding transaction.
REQ-011 SHALL assert icb_cmd_ready only in IDLE; command accepted in cycle N when valid&ready; addr, wdata, wmask, read registered.
REQ-012 SHALL, for CSR access, go IDLE->RSP: icb_rsp_valid at N+1.
REQ-013 SHALL, for usram read, go IDLE->RD (usram_addr driven N+1)->CAP (usram_rdata captured N+2)->RSP (rsp_valid N+3, rdata = selected 32-bit half).
REQ-014 SHALL, for usram write, do read-modify-write: RD->CAP->WR (usram_write_en=1 for exactly one cycle at N+3, wdata = captured word with bytes of selected half replaced where wmask bit set)->RSP (N+4).
REQ-015 SHALL hold icb_rsp_valid, rdata, err stable in RSP until icb_rsp_ready; RSP->IDLE on handshake; next command acceptable the following cycle.
REQ-016 SHALL keep usram_write_en 0 outside WR; usram_addr holds last issued index.
REQ-017 SHALL set err=1, rdata=0, no state change for: unmapped CSR offset, word index >= USRAM_DEPTH, usram access while BUSY=1 (no usram cycle issued, IDLE->RSP at N+1).
REQ-018 SHALL, on START write with bit0=1 and BUSY=0, pulse start for one cycle at N+1 and set BUSY; when BUSY=1 the write is ignored with err=0.
REQ-019 SHALL clear BUSY and set DONE on done=1; DONE set has priority over same-cycle W1C.
REQ-020 SHALL apply wmask to CSR writes byte-wise; wmask=0 write is a no-op with err=0.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-transaction, force FSM to IDLE, clear all CSRs, outputs 0: icb_cmd_ready=0 during reset then 1, icb_rsp_valid=0, start=0, usram_write_en=0, usram_addr=0, usram_wdata=0.
REQ-022 SHALL drop an in-flight transaction on reset with no response and no usram write.

Configuration
REQ-023 SHALL, with MHSA_IRQ_EN defined, add port irq out 1 = DONE bit0 AND IRQ_EN bit0 at CSR 0x14 (RW, reset 0), registered.
REQ-024 SHALL, without MHSA_IRQ_EN, have no irq port and treat offset 0x14 as unmapped (err=1).

Verification
REQ-025 SHALL cover: write 0x1000_0000 to 0x08 then read 0x08 -> rsp_valid at N+1, rdata 0x1000_0000, err 0; input_base=0x1000_0000.
REQ-026 SHALL cover: usram word 5 = 0x1122334455667788; write 0xAABBCCDD to 0x1002C with wmask 0b0011 -> usram_write_en once, wdata 0x1122CCDD55667788... corrected: addr[2]=1 selects upper half -> wdata 0x1122CCDD55667788; read 0x1002C -> 0x1122CCDD at N+3.
REQ-027 SHALL cover: write 1 to 0x00 -> start pulse one cycle, BUSY=1; second START write -> no pulse; usram read -> err=1; done pulse -> BUSY=0, DONE=1.
REQ-028 SHALL cover: done=1 same cycle as W1C write 1 to 0x04 -> DONE reads 1.
REQ-029 SHALL cover: icb_rsp_ready held 0 for 5 cycles -> rsp fields stable, icb_cmd_ready=0 throughout.
REQ-030 SHALL cover: rst_n low during WR-bound write at CAP -> no usram_write_en, no rsp_valid, CSRs 0 after release.

Source files
------------

// File: rtl/icb_usram_bridge_if.sv
// ICB slave bus bundle for icb_usram_bridge: command and response channels.
// The bridge takes the slave modport; a bus master takes the master modport.
interface icb_usram_bridge_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;

    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    modport master (
        output icb_cmd_valid,
        input  icb_cmd_ready,
        output icb_cmd_read,
        output icb_cmd_addr,
        output icb_cmd_wdata,
        output icb_cmd_wmask,
        input  icb_rsp_valid,
        output icb_rsp_ready,
        input  icb_rsp_rdata,
        input  icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid,
        output icb_cmd_ready,
        input  icb_cmd_read,
        input  icb_cmd_addr,
        input  icb_cmd_wdata,
        input  icb_cmd_wmask,
        output icb_rsp_valid,
        input  icb_rsp_ready,
        output icb_rsp_rdata,
        output icb_rsp_err
    );
endinterface

// File: rtl/icb_usram_bridge.sv
// ICB slave to unified-SRAM bridge with accelerator control CSRs.
// addr[16]=0 selects the CSR window, addr[16]=1 the 64-bit usram window
// (word index addr[15:3], 32-bit half select addr[2]). usram writes are
// read-modify-write so a 32-bit ICB write only touches its own half.
// Optional feature macro: MHSA_IRQ_EN adds an irq output and IRQ_EN CSR at 0x14.
module icb_usram_bridge #(
    parameter int unsigned USRAM_DEPTH = 4096  // power of two, at most 8192
) (
    input  logic               clk,
    input  logic               rst_n,
    icb_usram_bridge_if.slave  icb,
    output logic               start,
    input  logic               done,
    output logic [31:0]        input_base,
    output logic [31:0]        output_base,
    output logic [31:0]        usram_addr,
    output logic [63:0]        usram_wdata,
    output logic               usram_write_en,
    input  logic [63:0]        usram_rdata
`ifdef MHSA_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam logic [13:0] DEPTH_LIM = 14'(USRAM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StRsp
    } state_e;

    state_e      state_q;

    // Registered bus outputs
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Request captured at acceptance, used by the usram path
    logic        req_read;
    logic        req_half;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;

    // CSR state
    logic        busy_q;
    logic        done_q;
`ifdef MHSA_IRQ_EN
    logic        irq_en_q;
`endif

    // Command decode
    logic        cmd_fire;
    logic        usram_sel;
    logic [12:0] word_idx;
    logic        idx_ok;
    logic        usram_ok;
    logic [7:0]  csr_off;
    logic        csr_hit;
    logic [31:0] csr_rdata;
    logic        csr_wr;
    logic        cmd_err;
    logic        start_fire;
    logic        done_clr;

    // usram data path
    logic [31:0] cap_half;
    logic [31:0] new_half;
    logic [63:0] merged_word;

    logic        unused_addr;
    assign unused_addr = ^icb.icb_cmd_addr[31:17];

    assign icb.icb_cmd_ready = cmd_ready;
    assign icb.icb_rsp_valid = rsp_valid;
    assign icb.icb_rsp_rdata = rsp_rdata;
    assign icb.icb_rsp_err   = rsp_err;

    // Replace bytes of old_val with new_val where mask is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Decode the incoming command and the CSR read mux.
    always_comb begin
        cmd_fire  = icb.icb_cmd_valid & cmd_ready;
        usram_sel = icb.icb_cmd_addr[16];
        word_idx  = icb.icb_cmd_addr[15:3];
        idx_ok    = ({1'b0, word_idx} < DEPTH_LIM);
        usram_ok  = idx_ok & ~busy_q;
        csr_off   = icb.icb_cmd_addr[7:0];
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_off)
            8'h00:   csr_rdata = '0;
            8'h04:   csr_rdata = {31'b0, done_q};
            8'h08:   csr_rdata = input_base;
            8'h0C:   csr_rdata = output_base;
            8'h10:   csr_rdata = {31'b0, busy_q};
`ifdef MHSA_IRQ_EN
            8'h14:   csr_rdata = {31'b0, irq_en_q};
`endif
            default: csr_hit = 1'b0;
        endcase
        csr_wr     = cmd_fire & ~icb.icb_cmd_read & ~usram_sel & csr_hit;
        start_fire = csr_wr & (csr_off == 8'h00) & icb.icb_cmd_wmask[0]
                     & icb.icb_cmd_wdata[0] & ~busy_q;
        done_clr   = csr_wr & (csr_off == 8'h04) & icb.icb_cmd_wmask[0]
                     & icb.icb_cmd_wdata[0];
        cmd_err    = usram_sel ? ~usram_ok : ~csr_hit;
    end

    // Select the addressed half of the returned word and build the RMW word.
    always_comb begin
        cap_half    = req_half ? usram_rdata[63:32] : usram_rdata[31:0];
        new_half    = merge_bytes(cap_half, req_wdata, req_wmask);
        merged_word = req_half ? {new_half, usram_rdata[31:0]}
                               : {usram_rdata[63:32], new_half};
    end

    // Transaction FSM with registered bus and usram outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            usram_addr     <= '0;
            usram_wdata    <= '0;
            usram_write_en <= 1'b0;
            req_read       <= 1'b0;
            req_half       <= 1'b0;
            req_wdata      <= '0;
            req_wmask      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        req_read  <= icb.icb_cmd_read;
                        req_half  <= icb.icb_cmd_addr[2];
                        req_wdata <= icb.icb_cmd_wdata;
                        req_wmask <= icb.icb_cmd_wmask;
                        if (usram_sel && usram_ok) begin
                            usram_addr <= {19'b0, word_idx};
                            state_q    <= StRd;
                        end else begin
                            // CSR access or rejected usram access answers next cycle
                            rsp_valid <= 1'b1;
                            rsp_err   <= cmd_err;
                            rsp_rdata <= (!cmd_err && icb.icb_cmd_read) ? csr_rdata : '0;
                            state_q   <= StRsp;
                        end
                    end
                end
                StRd: begin
                    state_q <= StCap;
                end
                StCap: begin
                    if (req_read) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= cap_half;
                        state_q   <= StRsp;
                    end else begin
                        usram_wdata    <= merged_word;
                        usram_write_en <= 1'b1;
                        state_q        <= StWr;
                    end
                end
                StWr: begin
                    usram_write_en <= 1'b0;
                    rsp_valid      <= 1'b1;
                    rsp_err        <= 1'b0;
                    rsp_rdata      <= '0;
                    state_q        <= StRsp;
                end
                StRsp: begin
                    if (icb.icb_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // CSR registers, start pulse and done/busy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            input_base  <= '0;
            output_base <= '0;
        end else begin
            start <= start_fire;
            if (start_fire) begin
                busy_q <= 1'b1;
            end else if (done) begin
                busy_q <= 1'b0;
            end
            // done wins over a same-cycle W1C so a completion is never lost
            if (done) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            if (csr_wr && csr_off == 8'h08) begin
                input_base <= merge_bytes(input_base, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
            end
            if (csr_wr && csr_off == 8'h0C) begin
                output_base <= merge_bytes(output_base, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
            end
        end
    end

`ifdef MHSA_IRQ_EN
    // Interrupt enable CSR and registered interrupt output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (csr_wr && csr_off == 8'h14 && icb.icb_cmd_wmask[0]) begin
                irq_en_q <= icb.icb_cmd_wdata[0];
            end
            irq <= done_q & irq_en_q;
        end
    end
`endif

endmodule

// File: tb/tb_icb_usram_bridge.sv
// Directed bench for icb_usram_bridge: scoreboard of expected ICB responses
// plus a small usram model with one-cycle read latency.
module tb_icb_usram_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic        done;
    logic [31:0] input_base;
    logic [31:0] output_base;
    logic [31:0] usram_addr;
    logic [63:0] usram_wdata;
    logic        usram_write_en;
    logic [63:0] usram_rdata;
`ifdef MHSA_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    logic [63:0] last_wdata = '0;
    logic [63:0] mem [64];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    icb_usram_bridge_if bus();

    always #5 clk = ~clk;

    icb_usram_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icb            (bus),
        .start          (start),
        .done           (done),
        .input_base     (input_base),
        .output_base    (output_base),
        .usram_addr     (usram_addr),
        .usram_wdata    (usram_wdata),
        .usram_write_en (usram_write_en),
        .usram_rdata    (usram_rdata)
`ifdef MHSA_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    // usram model and event counters
    always @(posedge clk) begin
        if (usram_write_en) begin
            mem[usram_addr[5:0]] <= usram_wdata;
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= usram_wdata;
        end
        usram_rdata <= mem[usram_addr[5:0]];
        if (start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ICB transaction; called and returns at a negedge.
    task automatic xact(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int stall,
                        input logic done_at_accept);
        exp_t e;
        int   k;
        sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        bus.icb_cmd_valid = 1'b1;
        bus.icb_cmd_read  = rd;
        bus.icb_cmd_addr  = addr;
        bus.icb_cmd_wdata = wdata;
        bus.icb_cmd_wmask = mask;
        if (stall > 0) bus.icb_rsp_ready = 1'b0;
        if (done_at_accept) done = 1'b1;
        k = 0;
        while (bus.icb_cmd_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready", 64'(bus.icb_cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.icb_cmd_valid = 1'b0;
        done = 1'b0;
        k = 1;
        while (bus.icb_rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("rsp_latency", 64'(k), 64'(e.lat));
        chk("rsp_rdata", 64'(bus.icb_rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(bus.icb_rsp_err), 64'(e.err));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.icb_rsp_valid), 64'd1);
            chk("stall_rdata", 64'(bus.icb_rsp_rdata), 64'(e.rdata));
            chk("stall_err", 64'(bus.icb_rsp_err), 64'(e.err));
            chk("stall_cmd_ready", 64'(bus.icb_cmd_ready), 64'd0);
        end
        bus.icb_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int s0;
        bus.icb_cmd_valid = 1'b0;
        bus.icb_cmd_read  = 1'b0;
        bus.icb_cmd_addr  = '0;
        bus.icb_cmd_wdata = '0;
        bus.icb_cmd_wmask = '0;
        bus.icb_rsp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[5] = 64'h1122_3344_5566_7788;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.icb_cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.icb_rsp_valid), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_write_en", 64'(usram_write_en), 64'd0);
        chk("rst_usram_addr", 64'(usram_addr), 64'd0);
        chk("rst_usram_wdata", usram_wdata, 64'd0);
        chk("rst_input_base", 64'(input_base), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(bus.icb_cmd_ready), 64'd1);

        // CSR write/read of INPUT_BASE
        xact(1'b0, 32'h08, 32'h1000_0000, 4'hF, 32'h0, 1'b0, 1, 0, 1'b0);
        xact(1'b1, 32'h08, 32'h0, 4'h0, 32'h1000_0000, 1'b0, 1, 0, 1'b0);
        chk("input_base", 64'(input_base), 64'h1000_0000);

        // Byte masked CSR write, then a mask-0 no-op
        xact(1'b0, 32'h0C, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1, 0, 1'b0);
        chk("output_base_mask", 64'(output_base), 64'h00BB_00DD);
        xact(1'b0, 32'h0C, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1, 0, 1'b0);
        chk("output_base_nop", 64'(output_base), 64'h00BB_00DD);

        // usram read-modify-write to the upper half of word 5
        w0 = wr_cnt;
        xact(1'b0, 32'h1002C, 32'hAABB_CCDD, 4'b0011, 32'h0, 1'b0, 4, 0, 1'b0);
        chk("rmw_write_count", 64'(wr_cnt), 64'(w0 + 1));
        chk("rmw_wdata", last_wdata, 64'h1122_CCDD_5566_7788);
        chk("rmw_write_en_low", 64'(usram_write_en), 64'd0);
        xact(1'b1, 32'h1002C, 32'h0, 4'h0, 32'h1122_CCDD, 1'b0, 3, 0, 1'b0);
        xact(1'b1, 32'h10028, 32'h0, 4'h0, 32'h5566_7788, 1'b0, 3, 0, 1'b0);
        // Lower half, top byte only
        xact(1'b0, 32'h10028, 32'h0102_0304, 4'b1000, 32'h0, 1'b0, 4, 0, 1'b0);
        chk("rmw_lower", mem[5], 64'h1122_CCDD_0166_7788);

        // Unmapped CSR offsets
        xact(1'b1, 32'h18, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        xact(1'b0, 32'h20, 32'h5, 4'hF, 32'h0, 1'b1, 1, 0, 1'b0);
`ifdef MHSA_IRQ_EN
        xact(1'b1, 32'h14, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
`else
        xact(1'b1, 32'h14, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 1'b0);
`endif

        // Word index past USRAM_DEPTH (4096)
        w0 = wr_cnt;
        xact(1'b0, 32'h18000, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1, 0, 1'b0);
        chk("oob_no_write", 64'(wr_cnt), 64'(w0));
        xact(1'b1, 32'h18000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 1'b0);

        // START, BUSY, ignored re-start, usram blocked while busy
        s0 = start_cnt;
        xact(1'b0, 32'h00, 32'h1, 4'hF, 32'h0, 1'b0, 1, 0, 1'b0);
        chk("start_pulse", 64'(start_cnt), 64'(s0 + 1));
        chk("start_low", 64'(start), 64'd0);
        xact(1'b1, 32'h10, 32'h0, 4'h0, 32'h1, 1'b0, 1, 0, 1'b0);
        xact(1'b0, 32'h00, 32'h1, 4'hF, 32'h0, 1'b0, 1, 0, 1'b0);
        chk("restart_ignored", 64'(start_cnt), 64'(s0 + 1));
        xact(1'b1, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
        xact(1'b1, 32'h1002C, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        w0 = wr_cnt;
        xact(1'b0, 32'h1002C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1, 0, 1'b0);
        chk("busy_no_write", 64'(wr_cnt), 64'(w0));

        // Completion
        pulse_done();
        xact(1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
        xact(1'b1, 32'h04, 32'h0, 4'h0, 32'h1, 1'b0, 1, 0, 1'b0);

        // W1C, then W1C colliding with done
        xact(1'b0, 32'h04, 32'h1, 4'hF, 32'h0, 1'b0, 1, 0, 1'b0);
        xact(1'b1, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
        pulse_done();
        xact(1'b0, 32'h04, 32'h1, 4'hF, 32'h0, 1'b0, 1, 0, 1'b1);
        xact(1'b1, 32'h04, 32'h0, 4'h0, 32'h1, 1'b0, 1, 0, 1'b0);

`ifdef MHSA_IRQ_EN
        xact(1'b0, 32'h14, 32'h1, 4'hF, 32'h0, 1'b0, 1, 0, 1'b0);
        @(negedge clk);
        chk("irq", 64'(irq), 64'd1);
`endif

        // Response backpressure for five cycles
        xact(1'b1, 32'h08, 32'h0, 4'h0, 32'h1000_0000, 1'b0, 1, 5, 1'b0);

        // Reset while a write sits in CAP
        w0 = wr_cnt;
        bus.icb_cmd_valid = 1'b1;
        bus.icb_cmd_read  = 1'b0;
        bus.icb_cmd_addr  = 32'h10030;
        bus.icb_cmd_wdata = 32'hDEAD_BEEF;
        bus.icb_cmd_wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.icb_cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_write_en", 64'(usram_write_en), 64'd0);
        chk("midrst_rsp_valid", 64'(bus.icb_rsp_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(bus.icb_cmd_ready), 64'd0);
        chk("midrst_usram_addr", 64'(usram_addr), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_hold_we", 64'(usram_write_en), 64'd0);
            chk("midrst_hold_rv", 64'(bus.icb_rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_write", 64'(wr_cnt), 64'(w0));
        chk("midrst_mem6", mem[6], 64'd0);
        chk("midrst_input_base", 64'(input_base), 64'd0);
        chk("midrst_output_base", 64'(output_base), 64'd0);
        chk("midrst_rsp_valid_after", 64'(bus.icb_rsp_valid), 64'd0);
        xact(1'b1, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
        xact(1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
        xact(1'b1, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
